// File: rtl/cnn_core_mac_pkg.sv
// Shared widths, parameter-legality checks and saturation helper for the
// CNN core multiply-accumulate pipeline.
package cnn_core_mac_pkg;

  localparam int NUM_STAGE_MIN = 1;
  localparam int NUM_STAGE_MAX = 4;
  localparam int SAT_WIDTH_MAX = 64;

  // Unsigned weights gain a zero sign bit, so the product grows by one.
  function automatic int prod_width(input int w0, input int w1, input int signed1);
    return (signed1 != 0) ? (w0 + w1) : (w0 + w1 + 1);
  endfunction

  function automatic bit num_stage_ok(input int n);
    return (n >= NUM_STAGE_MIN) && (n <= NUM_STAGE_MAX);
  endfunction

  function automatic logic signed [63:0] sat_to(input logic signed [63:0] v, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cnn_core_mac_pipe_mul.sv
// Pipelined signed x (signed|unsigned) multiplier: one operand register stage
// followed by NUM_STAGE product stages, all advanced by a shared enable.
module cnn_core_mul_pipe
  import cnn_core_mac_pkg::*;
#(
  parameter int din0_WIDTH  = 16,
  parameter int din1_WIDTH  = 5,
  parameter int DIN1_SIGNED = 0,
  parameter int NUM_STAGE   = 2,
  localparam int P          = prod_width(din0_WIDTH, din1_WIDTH, DIN1_SIGNED)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  valid_i,
  input  logic                  last_i,
  input  logic [din0_WIDTH-1:0] din0_i,
  input  logic [din1_WIDTH-1:0] din1_i,
  output logic [P-1:0]          prod_o,
  output logic                  valid_o,
  output logic                  last_o
);

  localparam int BW = (DIN1_SIGNED != 0) ? din1_WIDTH : din1_WIDTH + 1;

  logic signed [BW-1:0]         b_ext;
  logic signed [din0_WIDTH-1:0] a_q;
  logic signed [BW-1:0]         b_q;
  logic                         op_vld_q;
  logic                         op_last_q;
  logic signed [P-1:0]          mul_c;

  logic [P-1:0]                 prod_chain [NUM_STAGE+1];
  logic [NUM_STAGE:0]           vld_chain;
  logic [NUM_STAGE:0]           last_chain;

  generate
    if (DIN1_SIGNED != 0) begin : g_b_signed
      assign b_ext = $signed(din1_i);
    end else begin : g_b_unsigned
      assign b_ext = $signed({1'b0, din1_i});
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q       <= '0;
      b_q       <= '0;
      op_vld_q  <= 1'b0;
      op_last_q <= 1'b0;
    end else if (en_i) begin
      a_q       <= $signed(din0_i);
      b_q       <= b_ext;
      op_vld_q  <= valid_i;
      op_last_q <= last_i;
    end
  end

  // Operands are widened to P first so the multiply is exact in P bits.
  assign mul_c         = P'(a_q) * P'(b_q);
  assign prod_chain[0] = mul_c;
  assign vld_chain[0]  = op_vld_q;
  assign last_chain[0] = op_last_q;

  generate
    for (genvar gi = 0; gi < NUM_STAGE; gi++) begin : g_stage
      logic [P-1:0] prod_q;
      logic         vld_q;
      logic         last_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          prod_q <= '0;
          vld_q  <= 1'b0;
          last_q <= 1'b0;
        end else if (en_i) begin
          prod_q <= prod_chain[gi];
          vld_q  <= vld_chain[gi];
          last_q <= last_chain[gi];
        end
      end

      assign prod_chain[gi+1] = prod_q;
      assign vld_chain[gi+1]  = vld_q;
      assign last_chain[gi+1] = last_q;
    end
  endgenerate

  assign prod_o  = prod_chain[NUM_STAGE];
  assign valid_o = vld_chain[NUM_STAGE];
  assign last_o  = last_chain[NUM_STAGE];

endmodule

// File: rtl/cnn_core_mac_pipe.sv
// Multiply-accumulate with valid/ready flow control: accumulates products over
// a run closed by in_last and emits one saturated result per run.
module cnn_core_mac_pipe
  import cnn_core_mac_pkg::*;
#(
  parameter int din0_WIDTH  = 16,
  parameter int din1_WIDTH  = 5,
  parameter int DIN1_SIGNED = 0,
  parameter int NUM_STAGE   = 2,
  parameter int ACC_WIDTH   = 32,
  parameter int dout_WIDTH  = 21
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int P = prod_width(din0_WIDTH, din1_WIDTH, DIN1_SIGNED);

  generate
    if (!num_stage_ok(NUM_STAGE)) begin : g_bad_num_stage
      $error("cnn_core_mac_pipe: NUM_STAGE out of range");
    end
    if (ACC_WIDTH < P || ACC_WIDTH > SAT_WIDTH_MAX || dout_WIDTH > SAT_WIDTH_MAX) begin : g_bad_width
      $error("cnn_core_mac_pipe: illegal ACC_WIDTH/dout_WIDTH");
    end
  endgenerate

  logic                  en;
  logic [P-1:0]          m_prod;
  logic                  m_vld;
  logic                  m_last;
  logic                  beat;

  logic [ACC_WIDTH-1:0]  prod_ext;
  logic [ACC_WIDTH-1:0]  acc_sum;
  logic                  wrap;
  logic [ACC_WIDTH-1:0]  acc_q,     acc_d;
  logic                  first_q;
  logic                  ovf_acc_q, ovf_acc_d;
  logic signed [63:0]    acc_wide;
  logic signed [63:0]    acc_sat;
  logic                  clipped;
  logic [dout_WIDTH-1:0] dout_q,    dout_d;
  logic                  ovf_q,     ovf_d;
  logic                  out_valid_q;

  // A pending, unaccepted result freezes the whole pipe; there is no skid.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;
  assign beat     = en && m_vld;

  cnn_core_mul_pipe #(
    .din0_WIDTH (din0_WIDTH),
    .din1_WIDTH (din1_WIDTH),
    .DIN1_SIGNED(DIN1_SIGNED),
    .NUM_STAGE  (NUM_STAGE)
  ) u_mul (
    .clk_i  (ap_clk),
    .rst_i  (ap_rst),
    .en_i   (en),
    .valid_i(in_valid),
    .last_i (in_last),
    .din0_i (din0),
    .din1_i (din1),
    .prod_o (m_prod),
    .valid_o(m_vld),
    .last_o (m_last)
  );

  always_comb begin
    prod_ext  = ACC_WIDTH'($signed(m_prod));
    acc_sum   = acc_q + prod_ext;
    wrap      = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                (acc_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    acc_d     = acc_sum;
    ovf_acc_d = ovf_acc_q | wrap;
    if (first_q) begin
      acc_d     = prod_ext;
      ovf_acc_d = 1'b0;
    end
    acc_wide = 64'($signed(acc_d));
    acc_sat  = sat_to(acc_wide, dout_WIDTH);
    clipped  = (acc_sat != acc_wide);
    dout_d   = acc_sat[dout_WIDTH-1:0];
    ovf_d    = ovf_acc_d | clipped;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      acc_q       <= '0;
      first_q     <= 1'b1;
      ovf_acc_q   <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (beat) begin
        acc_q     <= acc_d;
        ovf_acc_q <= ovf_acc_d;
        first_q   <= m_last;
      end
      if (beat && m_last) begin
        dout_q      <= dout_d;
        ovf_q       <= ovf_d;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cnn_core_mac_pipe.sv
// Directed bench for cnn_core_mac_pipe: default-parameter instance plus a
// signed-weight instance, checked with immediate assertions.
module tb_cnn_core_mac_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, out_ready;
  logic [15:0] din0;
  logic [4:0]  din1;
  logic        in_ready, out_valid, ovf;
  logic [20:0] dout;

  logic        s_in_valid, s_in_last, s_out_ready;
  logic [15:0] s_din0;
  logic [4:0]  s_din1;
  logic        s_in_ready, s_out_valid, s_ovf;
  logic [20:0] s_dout;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc_cnt = 0;
  int res_d[$];
  int res_c[$];

  always #5 clk = ~clk;

  cnn_core_mac_pipe u_dut (
    .ap_clk(clk), .ap_rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .din0(din0), .din1(din1), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .ovf(ovf)
  );

  cnn_core_mac_pipe #(.DIN1_SIGNED(1)) u_dut_s (
    .ap_clk(clk), .ap_rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .din0(s_din0), .din1(s_din1), .in_last(s_in_last),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .dout(s_dout), .ovf(s_ovf)
  );

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Record every completed result handshake with the cycle it happened in.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      res_d.push_back(int'($signed(dout)));
      res_c.push_back(cyc_cnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b, input bit l);
    bit took = 1'b0;
    in_valid = 1'b1;
    din0     = a[15:0];
    din1     = b[4:0];
    in_last  = l;
    for (int n = 0; n < 50 && !took; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) took = 1'b1;
      cyc();
    end
    if (!took) chk("send_accept", 64'(took), 1);
  endtask

  task automatic wait_out(input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
      else cyc();
    end
    chk({tag, "_arrive"}, 64'(seen), 1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; din0 = '0; din1 = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_last = 1'b0; s_din0 = '0; s_din1 = '0; s_out_ready = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_dout", $signed(dout), 0);
    chk("rst_ovf", 64'(ovf), 0);
    cyc();
    rst = 1'b0;
    cyc();

    // Three-term run, latency of NUM_STAGE+1 edges after the last beat.
    send(100, 3, 0);
    send(-50, 7, 0);
    send(20, 31, 1);
    in_valid = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    chk("run3_early_valid", 64'(out_valid), 0);
    cyc();
    @(negedge clk);
    chk("run3_valid", 64'(out_valid), 1);
    chk("run3_dout", $signed(dout), 570);
    chk("run3_ovf", 64'(ovf), 0);
    cyc();

    // Same operands, signed vs unsigned weight interpretation.
    s_in_valid = 1'b1; s_din0 = 16'd1000; s_din1 = 5'b11111; s_in_last = 1'b1;
    send(1000, 31, 1);
    in_valid = 1'b0;
    s_in_valid = 1'b0;
    cyc(); cyc(); cyc();
    @(negedge clk);
    chk("unsigned_valid", 64'(out_valid), 1);
    chk("unsigned_dout", $signed(dout), 31000);
    chk("signed_valid", 64'(s_out_valid), 1);
    chk("signed_dout", $signed(s_dout), -1000);
    cyc();

    // Saturation, then a clean run must not inherit the overflow flag.
    for (int i = 0; i < 40; i++) send(32767, 31, i == 39);
    in_valid = 1'b0;
    wait_out("sat");
    chk("sat_dout", $signed(dout), 1048575);
    chk("sat_ovf", 64'(ovf), 1);
    cyc();
    send(1, 1, 1);
    in_valid = 1'b0;
    wait_out("post_sat");
    chk("post_sat_dout", $signed(dout), 1);
    chk("post_sat_ovf", 64'(ovf), 0);
    cyc();

    // Backpressure: results 5..8 queued behind a stalled output, 9 held at input.
    res_d.delete(); res_c.delete();
    out_ready = 1'b0;
    send(5, 1, 1);
    send(6, 1, 1);
    send(7, 1, 1);
    din0 = 16'd8;
    cyc();
    din0 = 16'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 0);
      chk("stall_out_valid", 64'(out_valid), 1);
      chk("stall_dout", $signed(dout), 5);
      cyc();
    end
    out_ready = 1'b1;
    send(9, 1, 1);
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) cyc();
    chk("bp_count", res_d.size(), 5);
    for (int i = 0; i < 5 && i < res_d.size(); i++) chk("bp_order", res_d[i], 5 + i);

    // Reset mid-run discards the partial sum and in-flight beats.
    send(10, 1, 0);
    send(10, 1, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    send(4, 2, 1);
    in_valid = 1'b0;
    wait_out("rst_mid");
    chk("rst_mid_dout", $signed(dout), 8);
    chk("rst_mid_ovf", 64'(ovf), 0);
    cyc();

    // Throughput: eight one-term runs give eight back-to-back results.
    for (int i = 0; i < 4; i++) cyc();
    res_d.delete(); res_c.delete();
    for (int k = 1; k <= 8; k++) send(k, 1, 1);
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) cyc();
    chk("tput_count", res_d.size(), 8);
    for (int i = 0; i < 8 && i < res_d.size(); i++) begin
      chk("tput_dout", res_d[i], i + 1);
      chk("tput_gap", res_c[i] - res_c[0], i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
